// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchronizer, debounce counter, accepted level and
// single-cycle rise/fall pulses on each accepted change.
module sw_debounce_bit #(
    parameter int unsigned LOG2DELAY = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_i,
    output logic sw_db_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [LOG2DELAY-1:0] TERM_CNT = {LOG2DELAY{1'b1}};

    logic                 s1_q;
    logic                 s2_q;
    logic                 st_q;
    logic                 st_d;
    logic [LOG2DELAY-1:0] cnt_q;
    logic [LOG2DELAY-1:0] cnt_d;
    logic                 rise_q;
    logic                 rise_d;
    logic                 fall_q;
    logic                 fall_d;

    // State registers; s1/s2 form the synchronizer for the asynchronous pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            st_q   <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= sw_i;
            s2_q   <= s1_q;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // Any return to the accepted level restarts the window; the terminal count
    // commits the new level, so the counter never advances past all-ones.
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s2_q == st_q) begin
            cnt_d = '0;
        end else if (cnt_q == TERM_CNT) begin
            st_d   = s2_q;
            cnt_d  = '0;
            rise_d = s2_q;
            fall_d = ~s2_q;
        end else begin
            cnt_d = cnt_q + LOG2DELAY'(1);
        end
    end

    assign sw_db_o = st_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Switch-bus conditioner: one independent debouncer per bit plus bus-wide
// change and parity summaries.
module sw_debounce #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned LOG2DELAY = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic             parity
);

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        sw_debounce_bit #(
            .LOG2DELAY(LOG2DELAY)
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .sw_i   (sw[i]),
            .sw_db_o(sw_db[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

    // Summaries are taken straight from the per-bit registers.
    assign changed = |(rise | fall);
    assign parity  = ^sw_db;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with an 8-cycle window: directed vector table, then
// randomized switch activity checked against a sliding-window reference.
module tb_sw_debounce;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned L2D   = 3;
    localparam int unsigned WIN   = 1 << L2D;
    localparam int unsigned HIST  = WIN + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] sw_db;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;
    logic             parity;

    always #5 clk = ~clk;

    sw_debounce #(
        .WIDTH    (WIDTH),
        .LOG2DELAY(L2D)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw     (sw),
        .sw_db  (sw_db),
        .rise   (rise),
        .fall   (fall),
        .changed(changed),
        .parity (parity)
    );

    int total = 0;
    int bad   = 0;

    // Reference: raw samples taken at each edge; a level is accepted once the
    // synchronized copy (two edges late) has shown it for WIN straight edges.
    logic [WIDTH-1:0] samp [HIST];
    logic [WIDTH-1:0] m_st;
    logic [WIDTH-1:0] m_rise;
    logic [WIDTH-1:0] m_fall;

    task automatic model_reset();
        for (int i = 0; i < int'(HIST); i++) samp[i] = '0;
        m_st   = '0;
        m_rise = '0;
        m_fall = '0;
    endtask

    task automatic model_edge();
        logic all1;
        logic all0;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = int'(HIST) - 1; i > 0; i--) samp[i] = samp[i-1];
        samp[0] = sw;
        m_rise  = '0;
        m_fall  = '0;
        for (int b = 0; b < int'(WIDTH); b++) begin
            all1 = 1'b1;
            all0 = 1'b1;
            for (int k = 2; k < int'(HIST); k++) begin
                if (samp[k][b]) all0 = 1'b0;
                else            all1 = 1'b0;
            end
            if (all1 && !m_st[b]) begin
                m_st[b]   = 1'b1;
                m_rise[b] = 1'b1;
            end else if (all0 && m_st[b]) begin
                m_st[b]   = 1'b0;
                m_fall[b] = 1'b1;
            end
        end
    endtask

    task automatic check(input string name,
                         input logic [WIDTH-1:0] e_db, input logic [WIDTH-1:0] e_r,
                         input logic [WIDTH-1:0] e_f, input logic e_c, input logic e_p);
        total++;
        if (sw_db !== e_db || rise !== e_r || fall !== e_f || changed !== e_c || parity !== e_p) begin
            bad++;
            $display("FAIL %s t=%0t: got db=%h rise=%h fall=%h chg=%b par=%b, want db=%h rise=%h fall=%h chg=%b par=%b",
                     name, $time, sw_db, rise, fall, changed, parity, e_db, e_r, e_f, e_c, e_p);
        end
    endtask

    // One clock: advance model at the edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("model", m_st, m_rise, m_fall, |(m_rise | m_fall), ^m_st);
    endtask

    typedef struct {
        logic             rst;
        logic [WIDTH-1:0] sw;
        int               n;
        logic [WIDTH-1:0] db;
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] f;
        logic             c;
        logic             p;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r_, input logic [WIDTH-1:0] sw_, input int n_,
                                input logic [WIDTH-1:0] db_, input logic [WIDTH-1:0] ri_,
                                input logic [WIDTH-1:0] fa_, input logic c_, input logic p_);
        vec_t v;
        v.rst = r_; v.sw = sw_; v.n = n_; v.db = db_; v.r = ri_; v.f = fa_; v.c = c_; v.p = p_;
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        sw  = 16'hFFFF;
        model_reset();

        // Reset with all switches high, then release: all bits rise together.
        tbl.push_back(mk(1, 16'hFFFF, 2, 16'h0000, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 16'hFFFF, 9, 16'h0000, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 16'hFFFF, 1, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 16'hFFFF, 1, 16'hFFFF, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 9, 16'hFFFF, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 16'h0000, 16'h0000, 16'hFFFF, 1, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0));
        // Clean edge on bit 0.
        tbl.push_back(mk(0, 16'h0001, 9, 16'h0000, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 16'h0001, 1, 16'h0001, 16'h0001, 16'h0000, 1, 1));
        tbl.push_back(mk(0, 16'h0001, 1, 16'h0001, 16'h0000, 16'h0000, 0, 1));
        // Simultaneous fall on bit 1 and rise on bit 2.
        tbl.push_back(mk(0, 16'h0003, 9, 16'h0001, 16'h0000, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 16'h0003, 1, 16'h0003, 16'h0002, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 16'h0005, 1, 16'h0003, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 16'h0005, 8, 16'h0003, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 16'h0005, 1, 16'h0005, 16'h0004, 16'h0002, 1, 0));
        tbl.push_back(mk(0, 16'h0005, 1, 16'h0005, 16'h0000, 16'h0000, 0, 0));
        // Bounce on bit 3 with 3-cycle segments, then hold high.
        tbl.push_back(mk(0, 16'h000D, 3, 16'h0005, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 16'h0005, 3, 16'h0005, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 16'h000D, 3, 16'h0005, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 16'h0005, 3, 16'h0005, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 16'h000D, 9, 16'h0005, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 16'h000D, 1, 16'h000D, 16'h0008, 16'h0000, 1, 1));
        tbl.push_back(mk(0, 16'h000D, 1, 16'h000D, 16'h0000, 16'h0000, 0, 1));
        // Window boundary on bit 5: 7-cycle glitch rejected, 8-cycle accepted.
        tbl.push_back(mk(0, 16'h002D, 7, 16'h000D, 16'h0000, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 16'h000D, 9, 16'h000D, 16'h0000, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 16'h002D, 8, 16'h000D, 16'h0000, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 16'h000D, 1, 16'h000D, 16'h0000, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 16'h000D, 1, 16'h002D, 16'h0020, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 16'h000D, 7, 16'h002D, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 16'h000D, 1, 16'h000D, 16'h0000, 16'h0020, 1, 1));
        tbl.push_back(mk(0, 16'h000D, 1, 16'h000D, 16'h0000, 16'h0000, 0, 1));
        // Reset in the middle of bit 7's window.
        tbl.push_back(mk(0, 16'h008D, 4, 16'h000D, 16'h0000, 16'h0000, 0, 1));
        tbl.push_back(mk(1, 16'h008D, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 16'h008D, 9, 16'h0000, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 16'h008D, 1, 16'h008D, 16'h008D, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 16'h008D, 1, 16'h008D, 16'h0000, 16'h0000, 0, 0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            sw  = tbl[i].sw;
            if (tbl[i].rst && i > 0) begin
                #1;
                check("async_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
            end
            for (int k = 0; k < tbl[i].n; k++) step();
            check($sformatf("row%0d", i), tbl[i].db, tbl[i].r, tbl[i].f, tbl[i].c, tbl[i].p);
        end

        // Random activity with sparse bit flips and occasional resets.
        rst = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0)
                sw = sw ^ WIDTH'($urandom & $urandom & $urandom);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
